decode_pipe_stage: RTL
======================

# decode_pipe_stage

Registered, handshaked decode stage that sits between the fetch stage and the execute stage. It decodes one RV32I subset instruction per cycle into register indices, immediate, ALU op and control word, and holds them in an ID/EX output register. It uses a valid/ready protocol on both sides and detects load-use hazards against the instruction it currently holds. When a hazard is found, it inserts a single bubble.

## Interface
Parameters:
- INSTR_SIZE, 32, instruction width
- WORD_SIZE, 32, data/immediate width
- NUM_A_REGS, 32, architectural registers; index width is $clog2(NUM_A_REGS)
- ALU_OP_SIZE, 4, ALU opcode width
- CONTR_SIG_SIZE, 5, control word width; bits: 0 valid, 1 regwrite, 2 alusrc, 3 memre, 4 memwr

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  discard held and incoming instruction
- in_valid_i  in  1  fetch offers instr_i/pc_i
- in_ready_o  out  1  stage accepts this cycle
- instr_i  in  INSTR_SIZE  instruction
- pc_i  in  WORD_SIZE  instruction address
- out_valid_o  out  1  output register holds an instruction
- out_ready_i  in  1  execute consumes this cycle
- pc_o  out  WORD_SIZE  registered pc
- rd_o / rs1_o / rs2_o  out  $clog2(NUM_A_REGS) each  registered indices
- imm_o  out  WORD_SIZE  registered sign-extended immediate
- alu_op_o  out  ALU_OP_SIZE  registered ALU op
- control_o  out  CONTR_SIG_SIZE  registered control word
- illegal_o  out  1  sticky illegal-instruction flag; tied 0 without ILLEGAL_TRAP_EN

## Operation
- ALU codes: ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 1000, SRA 1001, SLL 1010, SRL 1011.
- R (0110011): add, sub, and, or, xor, sll, srl, sra. funct3 and funct7 are both checked. rd, rs1 and rs2 are used. Control is valid, regwrite.
- I (0010011): addi, andi, ori, xori, slli, srli, srai. Shifts check funct7; imm = sext(instr[31:20]). Control is valid, regwrite, alusrc.
- L (0000011): lw only (funct3 010). Control is valid, regwrite, alusrc, memre. ALU op is ADD.
- S (0100011): sw only (funct3 010). imm = sext({instr[31:25], instr[11:7]}). Control is valid, alusrc, memwr. rd = 0.
- LUI (0110111): imm = {instr[31:12], 12'b0}. rs1 = 0 and rs2 = 0. ALU op is ADD. Control is valid, regwrite, alusrc.
- Fields an instruction does not use are driven 0.
- Illegal instruction (any unlisted opcode/funct combination):
  - control = 0 and ALU op = ADD, so it decodes as a nop.
  - indices and immediate are 0.
- Load-use hazard: stall = out_valid_o & control_o[3] & (rd_o != 0) & in_valid_i & ((dec_rs1 == rd_o) | (dec_rs2 == rd_o)).
  - Only registers the incoming instruction actually uses are compared.
- in_ready_o = (!out_valid_o | out_ready_i) & !stall & !flush_i & !halt, where halt is the sticky illegal state (see Configuration).
- On accept (in_valid_i & in_ready_o), the output register loads the decoded fields and out_valid_o becomes 1.
- On consume without accept, out_valid_o becomes 0.
- Bubble on stall: when the load is consumed, the register empties for one cycle. The dependent instruction is accepted the next cycle.

## Timing
- Reset values: out_valid_o=0, pc_o=0, rd/rs1/rs2_o=0, imm_o=0, alu_op_o=ADD (0010), control_o=0, illegal_o=0. in_ready_o=1 out of reset.
- Latency is 1 cycle from accept to out_valid_o. Throughput is 1 per cycle while out_ready_i=1 and no stall.
- While out_valid_o=1 and out_ready_i=0, all registered outputs hold stable.
- A consume and an accept in the same cycle reload the register; out_valid_o stays 1.
- flush_i has priority over everything: next cycle out_valid_o=0 and nothing is accepted that cycle.
- Reset asserted mid-operation immediately forces the reset values; an in-flight instruction is lost.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - an accepted illegal instruction is still registered as a nop;
  - illegal_o is set the cycle after the accept and stays set;
  - in_ready_o is held 0 until flush_i, which clears illegal_o.
- ILLEGAL_TRAP_EN undefined: illegal instructions flow through as nops and illegal_o is constant 0.

## Structure
- Package decode_pkg holds:
  - opcode constants (R, I, L, S, LUI);
  - ALU op codes;
  - control bit indices;
  - a packed struct for decoded fields.
- Sub-module decode_comb is the purely combinational decoder (instr to struct) and is unit-testable on its own. decode_pipe_stage holds the handshake, hazard logic and output register.

## Test plan
- Streaming: add x3,x1,x2, then sub x4,x3,x1, then xori x5,x4,-1 with out_ready_i=1. Outputs appear 1 cycle after each accept, with alu_op 0010, 0110, 1000. imm of xori = 0xFFFFFFFF.
- Backpressure: out_ready_i=0 for 3 cycles with sw held. Outputs are stable, in_ready_o=0, and imm is the split S immediate, e.g. sw x2,-4(x1) gives 0xFFFFFFFC.
- Load-use: lw x5,0(x1) followed by add x6,x5,x7. Exactly one bubble cycle appears (out_valid_o=0) between them. The same sequence with rd=x0 gives no bubble.
- LUI: lui x1,0x12345 gives imm 0x12345000, rs1=0, control 00111.
- Illegal with ILLEGAL_TRAP_EN: opcode 1111111 gives control 0, then illegal_o=1 and in_ready_o=0. flush_i then clears both.
- Flush and reset: flush_i while a held instruction is stalled gives out_valid_o=0 the next cycle. rst_ni low mid-stream returns every output to its reset value asynchronously.

Source files
------------

// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the decode pipeline stage:
//   - base widths of the decoded fields
//   - RV32I opcode and funct7 constants for the supported subset
//   - ALU operation codes
//   - control-word bit positions and a helper to build a control word
//   - dec_t, the packed record produced by the combinational decoder
// -----------------------------------------------------------------------------
package decode_pkg;

  localparam int INSTR_W = 32;
  localparam int WORD_W  = 32;
  localparam int REG_W   = 5;
  localparam int ALU_W   = 4;
  localparam int CTRL_W  = 5;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_L   = 7'b0000011;
  localparam logic [6:0] OPC_S   = 7'b0100011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;  // sub / sra / srai

  typedef enum logic [ALU_W-1:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_XOR = 4'b1000,
    ALU_SRA = 4'b1001,
    ALU_SLL = 4'b1010,
    ALU_SRL = 4'b1011
  } alu_op_e;

  localparam int CTRL_VALID    = 0;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_ALUSRC   = 2;
  localparam int CTRL_MEMRE    = 3;
  localparam int CTRL_MEMWR    = 4;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [WORD_W-1:0] imm;
    alu_op_e           alu_op;
    logic [CTRL_W-1:0] ctrl;
    logic              illegal;
  } dec_t;

  // Every legal instruction carries the valid bit; the rest is per class.
  function automatic logic [CTRL_W-1:0] ctrl_word(input logic regwrite,
                                                  input logic alusrc,
                                                  input logic memre,
                                                  input logic memwr);
    logic [CTRL_W-1:0] w;
    w                = '0;
    w[CTRL_VALID]    = 1'b1;
    w[CTRL_REGWRITE] = regwrite;
    w[CTRL_ALUSRC]   = alusrc;
    w[CTRL_MEMRE]    = memre;
    w[CTRL_MEMWR]    = memwr;
    return w;
  endfunction

  // Decoded nop: what an unknown encoding (and reset) turns into.
  localparam dec_t DEC_NOP = '{rd: '0, rs1: '0, rs2: '0, imm: '0,
                               alu_op: ALU_ADD, ctrl: '0, illegal: 1'b0};

endpackage

// File: rtl/decode_comb.sv
// -----------------------------------------------------------------------------
// decode_comb
// Purely combinational RV32I-subset decoder (R, I, lw, sw, lui).
// Ports:
//   instr_i  in   INSTR_W  raw instruction
//   dec_o    out  dec_t    decoded indices, immediate, ALU op, control, illegal
// Fields an instruction does not use are 0; an unknown opcode/funct
// combination decodes to DEC_NOP with the illegal flag set.
// -----------------------------------------------------------------------------
module decode_comb
  import decode_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output dec_t               dec_o
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [REG_W-1:0]  rd_f;
  logic [REG_W-1:0]  rs1_f;
  logic [REG_W-1:0]  rs2_f;
  logic [WORD_W-1:0] imm_i;
  logic [WORD_W-1:0] imm_s;
  logic [WORD_W-1:0] imm_u;

  logic    legal;
  alu_op_e alu_sel;
  dec_t    fields;

  assign opcode = instr_i[6:0];
  assign rd_f   = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1_f  = instr_i[19:15];
  assign rs2_f  = instr_i[24:20];
  assign funct7 = instr_i[31:25];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_u = {instr_i[31:12], 12'b0};

  always_comb begin
    fields  = DEC_NOP;
    legal   = 1'b0;
    alu_sel = ALU_ADD;
    dec_o   = DEC_NOP;

    case (opcode)
      OPC_R: begin
        legal = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: alu_sel = ALU_ADD;
          {F7_ALT,  3'b000}: alu_sel = ALU_SUB;
          {F7_BASE, 3'b111}: alu_sel = ALU_AND;
          {F7_BASE, 3'b110}: alu_sel = ALU_OR;
          {F7_BASE, 3'b100}: alu_sel = ALU_XOR;
          {F7_BASE, 3'b001}: alu_sel = ALU_SLL;
          {F7_BASE, 3'b101}: alu_sel = ALU_SRL;
          {F7_ALT,  3'b101}: alu_sel = ALU_SRA;
          default:           legal   = 1'b0;
        endcase
        fields.rd   = rd_f;
        fields.rs1  = rs1_f;
        fields.rs2  = rs2_f;
        fields.ctrl = ctrl_word(1'b1, 1'b0, 1'b0, 1'b0);
      end

      OPC_I: begin
        legal = 1'b1;
        case (funct3)
          3'b000: alu_sel = ALU_ADD;
          3'b111: alu_sel = ALU_AND;
          3'b110: alu_sel = ALU_OR;
          3'b100: alu_sel = ALU_XOR;
          3'b001: begin
            alu_sel = ALU_SLL;
            legal   = (funct7 == F7_BASE);
          end
          3'b101: begin
            if (funct7 == F7_BASE)     alu_sel = ALU_SRL;
            else if (funct7 == F7_ALT) alu_sel = ALU_SRA;
            else                       legal   = 1'b0;
          end
          default: legal = 1'b0;
        endcase
        // Shifts keep the full instr[31:20] field as their immediate.
        fields.rd   = rd_f;
        fields.rs1  = rs1_f;
        fields.imm  = imm_i;
        fields.ctrl = ctrl_word(1'b1, 1'b1, 1'b0, 1'b0);
      end

      OPC_L: begin
        legal       = (funct3 == 3'b010);
        fields.rd   = rd_f;
        fields.rs1  = rs1_f;
        fields.imm  = imm_i;
        fields.ctrl = ctrl_word(1'b1, 1'b1, 1'b1, 1'b0);
      end

      OPC_S: begin
        legal       = (funct3 == 3'b010);
        fields.rs1  = rs1_f;
        fields.rs2  = rs2_f;
        fields.imm  = imm_s;
        fields.ctrl = ctrl_word(1'b0, 1'b1, 1'b0, 1'b1);
      end

      OPC_LUI: begin
        legal       = 1'b1;
        fields.rd   = rd_f;
        fields.imm  = imm_u;
        fields.ctrl = ctrl_word(1'b1, 1'b1, 1'b0, 1'b0);
      end

      default: legal = 1'b0;
    endcase

    fields.alu_op = alu_sel;

    if (legal) dec_o = fields;
    else       dec_o.illegal = 1'b1;
  end

endmodule

// File: rtl/decode_pipe_stage.sv
// -----------------------------------------------------------------------------
// decode_pipe_stage
// Registered decode stage between fetch and execute. Decodes one instruction
// per cycle into an ID/EX output register and inserts a single bubble on a
// load-use hazard against the instruction it currently holds.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                drop the held and the incoming instruction
//   in_valid_i/in_ready_o  fetch-side handshake, instr_i / pc_i payload
//   out_valid_o/out_ready_i execute-side handshake
//   pc_o, rd_o, rs1_o, rs2_o, imm_o, alu_op_o, control_o  registered fields
//   illegal_o              sticky illegal-instruction flag
//
// Build option: define ILLEGAL_TRAP_EN to make an accepted illegal
// instruction set illegal_o and stall the input until flush_i. Without it,
// illegal instructions pass through as nops and illegal_o is tied 0.
// -----------------------------------------------------------------------------
module decode_pipe_stage
  import decode_pkg::*;
#(
  parameter int INSTR_SIZE     = 32,
  parameter int WORD_SIZE      = 32,
  parameter int NUM_A_REGS     = 32,
  parameter int ALU_OP_SIZE    = 4,
  parameter int CONTR_SIG_SIZE = 5,
  localparam int IDX_W         = $clog2(NUM_A_REGS)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [INSTR_SIZE-1:0]     instr_i,
  input  logic [WORD_SIZE-1:0]      pc_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [WORD_SIZE-1:0]      pc_o,
  output logic [IDX_W-1:0]          rd_o,
  output logic [IDX_W-1:0]          rs1_o,
  output logic [IDX_W-1:0]          rs2_o,
  output logic [WORD_SIZE-1:0]      imm_o,
  output logic [ALU_OP_SIZE-1:0]    alu_op_o,
  output logic [CONTR_SIG_SIZE-1:0] control_o,
  output logic                      illegal_o
);

  // Handshake: a beat moves on a side only in a cycle where both valid and
  // ready are high at the rising edge. A producer holds valid and payload
  // stable until accepted; ready may depend combinationally on valid and on
  // the incoming instruction (hazard check), never the other way round.

  dec_t dec;

  decode_comb u_decode_comb (
    .instr_i (instr_i),
    .dec_o   (dec)
  );

  logic                      out_valid_q, out_valid_d;
  logic [WORD_SIZE-1:0]      pc_q,        pc_d;
  logic [IDX_W-1:0]          rd_q,        rd_d;
  logic [IDX_W-1:0]          rs1_q,       rs1_d;
  logic [IDX_W-1:0]          rs2_q,       rs2_d;
  logic [WORD_SIZE-1:0]      imm_q,       imm_d;
  logic [ALU_OP_SIZE-1:0]    alu_op_q,    alu_op_d;
  logic [CONTR_SIG_SIZE-1:0] ctrl_q,      ctrl_d;

  logic halt;
  logic stall;
  logic in_ready;
  logic accept;
  logic consume;

  // Unused source registers decode to 0 and rd_q must be non-zero, so an
  // index that the incoming instruction does not read can never match.
  assign stall = out_valid_q & ctrl_q[CTRL_MEMRE] & (rd_q != '0) & in_valid_i &
                 ((dec.rs1 == rd_q) | (dec.rs2 == rd_q));

  assign in_ready = (~out_valid_q | out_ready_i) & ~stall & ~flush_i & ~halt;
  assign accept   = in_valid_i & in_ready;
  assign consume  = out_valid_q & out_ready_i;

  // While stalled, consuming the load empties the register (the bubble);
  // the dependent instruction is accepted the following cycle.
  always_comb begin
    out_valid_d = out_valid_q;
    pc_d        = pc_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    alu_op_d    = alu_op_q;
    ctrl_d      = ctrl_q;

    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      pc_d        = pc_i;
      rd_d        = dec.rd;
      rs1_d       = dec.rs1;
      rs2_d       = dec.rs2;
      imm_d       = dec.imm;
      alu_op_d    = dec.alu_op;
      ctrl_d      = dec.ctrl;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      alu_op_q    <= ALU_ADD;
      ctrl_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      pc_q        <= pc_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      imm_q       <= imm_d;
      alu_op_q    <= alu_op_d;
      ctrl_q      <= ctrl_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  // Sticky trap: set by accepting an illegal encoding, cleared only by flush.
  logic halt_q, halt_d;

  always_comb begin
    halt_d = halt_q;
    if (flush_i)                    halt_d = 1'b0;
    else if (accept && dec.illegal) halt_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) halt_q <= 1'b0;
    else         halt_q <= halt_d;
  end

  assign halt = halt_q;
`else
  logic unused_illegal;
  assign unused_illegal = dec.illegal;
  assign halt           = 1'b0;
`endif

  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid_q;
  assign pc_o        = pc_q;
  assign rd_o        = rd_q;
  assign rs1_o       = rs1_q;
  assign rs2_o       = rs2_q;
  assign imm_o       = imm_q;
  assign alu_op_o    = alu_op_q;
  assign control_o   = ctrl_q;
  assign illegal_o   = halt;

endmodule
